// File: rtl/maze_env_stepper.sv
// One-step environment for a 5x5 grid maze: accepts a move, returns (state, next_state, reward, done).
// Optional macro WALL_BUMP_PENALTY_EN makes an off-grid bump cost -1 instead of 0.
module maze_env_stepper #(
   parameter int START_STATE = 1,
   parameter int GOAL_STATE  = 25,
   parameter int MAX_STEPS   = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        act_valid,
   output logic        act_ready,
   input  logic [1:0]  action,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  state,
   output logic [5:0]  next_state,
   output logic [15:0] reward,
   output logic        done,
   output logic [4:0]  step_count,
   output logic [15:0] episode_count
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // once out_valid rises, it and all result fields hold until out_ready is seen high.
   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} fsm_t;

`ifdef WALL_BUMP_PENALTY_EN
   localparam logic [15:0] BUMP_REWARD = 16'hFFFF;
`else
   localparam logic [15:0] BUMP_REWARD = 16'h0000;
`endif

   fsm_t        fsm_q, fsm_d;
   logic [5:0]  pos_q, next_state_q;
   logic [15:0] reward_q, episode_q;
   logic        done_q;
   logic [4:0]  step_q;
   logic        accept, handshake;
   logic [5:0]  pos_m1, col, moved;
   logic [4:0]  step_inc;
   logic        goal, timeout, hazard, bump;
   logic [15:0] reward_d;

   assign accept    = act_valid && act_ready;
   assign handshake = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) fsm_q <= IDLE;
      else     fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (accept)    fsm_d = HOLD;
         HOLD:    if (handshake) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   always_comb begin
      act_ready = en && (fsm_q == IDLE);
      out_valid = (fsm_q == HOLD);
   end

   // Column is derived from the 0-based cell index; row checks use the cell number directly.
   always_comb begin
      pos_m1 = pos_q - 6'd1;
      col    = pos_m1 % 6'd5;
      moved  = pos_q;
      case (action)
         2'd0: if (pos_q > 6'd5)   moved = pos_q - 6'd5;
         2'd1: if (pos_q <= 6'd20) moved = pos_q + 6'd5;
         2'd2: if (col != 6'd0)    moved = pos_q - 6'd1;
         2'd3: if (col != 6'd4)    moved = pos_q + 6'd1;
         default: moved = pos_q;
      endcase
   end

   always_comb begin
      step_inc = step_q + 5'd1;
      goal     = (moved == 6'(GOAL_STATE));
      timeout  = (step_inc == 5'(MAX_STEPS));
      hazard   = moved inside {6'd3, 6'd4, 6'd7, 6'd13, 6'd14, 6'd17, 6'd19, 6'd22};
      bump     = (moved == pos_q);
      if (goal)         reward_d = 16'h0064;
      else if (timeout) reward_d = 16'hFFCE;
      else if (hazard)  reward_d = 16'hFF9C;
      else if (bump)    reward_d = BUMP_REWARD;
      else              reward_d = 16'h0000;
   end

   // accept only fires in IDLE and handshake only in HOLD, so the branches never compete.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q        <= 6'(START_STATE);
         next_state_q <= 6'(START_STATE);
         reward_q     <= 16'h0000;
         done_q       <= 1'b0;
         step_q       <= 5'd0;
         episode_q    <= 16'd0;
      end else if (accept) begin
         next_state_q <= moved;
         reward_q     <= reward_d;
         done_q       <= goal || timeout || hazard;
         step_q       <= step_inc;
      end else if (handshake) begin
         if (done_q) begin
            pos_q     <= 6'(START_STATE);
            step_q    <= 5'd0;
            episode_q <= episode_q + 16'd1;
         end else begin
            pos_q     <= next_state_q;
         end
      end
   end

   assign state         = pos_q;
   assign next_state    = next_state_q;
   assign reward        = reward_q;
   assign done          = done_q;
   assign step_count    = step_q;
   assign episode_count = episode_q;

endmodule

// File: tb/tb_maze_env_stepper.sv
// Directed bench for maze_env_stepper: instance a uses default parameters, instance b starts
// at cell 18 with a 3-step limit so the goal is reachable and coincides with the timeout.
module tb_maze_env_stepper;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        en_a = 1'b1, act_valid_a = 1'b0, out_ready_a = 1'b0;
   logic [1:0]  action_a = 2'd0;
   logic        act_ready_a, out_valid_a, done_a;
   logic [5:0]  state_a, next_state_a;
   logic [15:0] reward_a, episode_a;
   logic [4:0]  step_a;

   logic        en_b = 1'b1, act_valid_b = 1'b0, out_ready_b = 1'b0;
   logic [1:0]  action_b = 2'd0;
   logic        act_ready_b, out_valid_b, done_b;
   logic [5:0]  state_b, next_state_b;
   logic [15:0] reward_b, episode_b;
   logic [4:0]  step_b;

   int total = 0;
   int bad   = 0;

`ifdef WALL_BUMP_PENALTY_EN
   localparam logic [15:0] EXP_BUMP = 16'hFFFF;
`else
   localparam logic [15:0] EXP_BUMP = 16'h0000;
`endif

   maze_env_stepper u_dut_a (
      .clk(clk), .rst(rst), .en(en_a), .act_valid(act_valid_a), .act_ready(act_ready_a),
      .action(action_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .state(state_a), .next_state(next_state_a), .reward(reward_a), .done(done_a),
      .step_count(step_a), .episode_count(episode_a)
   );

   maze_env_stepper #(.START_STATE(18), .GOAL_STATE(25), .MAX_STEPS(3)) u_dut_b (
      .clk(clk), .rst(rst), .en(en_b), .act_valid(act_valid_b), .act_ready(act_ready_b),
      .action(action_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .state(state_b), .next_state(next_state_b), .reward(reward_b), .done(done_b),
      .step_count(step_b), .episode_count(episode_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Offer one action for a single edge; the result must be valid right after that edge.
   task automatic step(input int sel, input logic [1:0] a);
      if (sel == 0) begin act_valid_a = 1'b1; action_a = a; end
      else          begin act_valid_b = 1'b1; action_b = a; end
      @(posedge clk); #1;
      act_valid_a = 1'b0;
      act_valid_b = 1'b0;
   endtask

   task automatic handshake(input int sel);
      if (sel == 0) out_ready_a = 1'b1; else out_ready_b = 1'b1;
      @(posedge clk); #1;
      out_ready_a = 1'b0;
      out_ready_b = 1'b0;
      chk("hs_valid_low", sel ? out_valid_b : out_valid_a, 0);
   endtask

   task automatic check_res(input int sel, input string tag, input logic [5:0] st,
                            input logic [5:0] ns, input logic [15:0] rw, input logic dn,
                            input logic [4:0] sc);
      chk({tag, "_valid"}, sel ? out_valid_b  : out_valid_a,  1);
      chk({tag, "_state"}, sel ? state_b      : state_a,      st);
      chk({tag, "_next"},  sel ? next_state_b : next_state_a, ns);
      chk({tag, "_rew"},   sel ? reward_b     : reward_a,     rw);
      chk({tag, "_done"},  sel ? done_b       : done_a,       dn);
      chk({tag, "_step"},  sel ? step_b       : step_a,       sc);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values.
      chk("rst_valid", out_valid_a, 0);
      chk("rst_state", state_a, 1);
      chk("rst_next", next_state_a, 1);
      chk("rst_rew", reward_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_step", step_a, 0);
      chk("rst_ep", episode_a, 0);
      chk("rst_ready", act_ready_a, 1);
      chk("rst_state_b", state_b, 18);

      // Episode 1: right to 2, bump up at 2, right into hazard 3.
      step(0, 2'd3);
      check_res(0, "r1", 6'd1, 6'd2, 16'h0000, 1'b0, 5'd1);
      chk("r1_ready_busy", act_ready_a, 0);
      handshake(0);
      chk("r1_pos", state_a, 2);
      step(0, 2'd0);
      check_res(0, "bump_up2", 6'd2, 6'd2, EXP_BUMP, 1'b0, 5'd2);
      handshake(0);
      step(0, 2'd3);
      check_res(0, "hazard3", 6'd2, 6'd3, 16'hFF9C, 1'b1, 5'd3);
      handshake(0);
      chk("hz_ep", episode_a, 1);
      chk("hz_state", state_a, 1);
      chk("hz_step", step_a, 0);
      chk("hz_idle_next", next_state_a, 3);

      // en low blocks acceptance.
      en_a = 1'b0; act_valid_a = 1'b1;
      #1 chk("en_low_ready", act_ready_a, 0);
      @(posedge clk); #1;
      chk("en_low_no_accept", out_valid_a, 0);
      act_valid_a = 1'b0; en_a = 1'b1;

      // Episode 2: bump at cell 1, then shuttle 1<->6 until the 15-step timeout.
      step(0, 2'd0);
      check_res(0, "bump_up1", 6'd1, 6'd1, EXP_BUMP, 1'b0, 5'd1);
      handshake(0);
      for (int i = 2; i <= 15; i++) begin
         step(0, (i % 2 == 0) ? 2'd1 : 2'd0);
         check_res(0, $sformatf("to%0d", i), (i % 2 == 0) ? 6'd1 : 6'd6,
                   (i % 2 == 0) ? 6'd6 : 6'd1, (i == 15) ? 16'hFFCE : 16'h0000,
                   (i == 15), 5'(i));
         handshake(0);
      end
      chk("to_ep", episode_a, 2);
      chk("to_state", state_a, 1);
      chk("to_step", step_a, 0);

      // Instance b: 18 -> 23 -> 24 -> 25, goal on the step that also hits the limit.
      step(1, 2'd1);
      check_res(1, "b1", 6'd18, 6'd23, 16'h0000, 1'b0, 5'd1);
      handshake(1);
      step(1, 2'd3);
      check_res(1, "b2", 6'd23, 6'd24, 16'h0000, 1'b0, 5'd2);
      handshake(1);
      step(1, 2'd3);
      check_res(1, "goal", 6'd24, 6'd25, 16'h0064, 1'b1, 5'd3);
      en_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_res(1, $sformatf("hold%0d", i), 6'd24, 6'd25, 16'h0064, 1'b1, 5'd3);
      end
      en_b = 1'b1;
      handshake(1);
      chk("goal_ep", episode_b, 1);
      chk("goal_state", state_b, 18);

      // Reset while a result is pending discards it.
      step(0, 2'd3);
      check_res(0, "pre_rst", 6'd1, 6'd2, 16'h0000, 1'b0, 5'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("hold_rst_valid", out_valid_a, 0);
      chk("hold_rst_step", step_a, 0);
      chk("hold_rst_state", state_a, 1);
      chk("hold_rst_next", next_state_a, 1);
      chk("hold_rst_ep", episode_a, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
